// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) main-memory arbiter: 8-word pipelined block fills and single-word writes.
// Optional macro MEM_ARB_RR_EN turns the fixed D-over-I priority into round-robin for simultaneous requests.
module mem_arbiter #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [15:0]       i_addr,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [15:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              i_data_valid,
    output logic              d_data_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic [2:0]        fill_word,
    output logic              i_done,
    output logic              d_done,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [15:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t              state_q, state_d;
    logic                owner_d_q, owner_d_d;     // 1 = D-cache owns the transaction
    logic [2:0]          issue_cnt_q, issue_cnt_d;
    logic [2:0]          ret_cnt_q, ret_cnt_d;
    logic [11:0]         base_q, base_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_wr_q, mem_wr_d;
    logic [15:0]         mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                busy_q, busy_d;
`ifdef MEM_ARB_RR_EN
    logic                rr_d_first_q, rr_d_first_d;
`endif

    logic                pick_d;
    logic                gwrite;
    logic [15:0]         gaddr;
    logic                accept;
    logic                fill_last;

    always_comb begin
`ifdef MEM_ARB_RR_EN
        pick_d = d_req && (!i_req || rr_d_first_q);
`else
        pick_d = d_req;
`endif
        gaddr     = pick_d ? d_addr : i_addr;
        gwrite    = pick_d && d_wr;
        accept    = (state_q == FILL) && mem_valid;
        fill_last = accept && (ret_cnt_q == 3'd7);

        state_d     = state_q;
        owner_d_d   = owner_d_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        base_d      = base_q;
        mem_en_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = 16'h0000;
        mem_wdata_d = '0;
`ifdef MEM_ARB_RR_EN
        rr_d_first_d = rr_d_first_q;
`endif

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    owner_d_d   = pick_d;
                    base_d      = gaddr[15:4];
                    issue_cnt_d = 3'd0;
                    ret_cnt_d   = 3'd0;
                    mem_en_d    = 1'b1;
`ifdef MEM_ARB_RR_EN
                    rr_d_first_d = !pick_d;
`endif
                    if (gwrite) begin
                        state_d     = WRITE;
                        mem_wr_d    = 1'b1;
                        mem_addr_d  = gaddr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        state_d    = FILL;
                        mem_addr_d = {gaddr[15:4], 4'b0000};
                    end
                end
            end
            FILL: begin
                // Issue side runs ahead of returns; mem_en_q marks words still to be issued.
                if (mem_en_q && (issue_cnt_q != 3'd7)) begin
                    issue_cnt_d = issue_cnt_q + 3'd1;
                    mem_en_d    = 1'b1;
                    mem_addr_d  = {base_q, issue_cnt_q + 3'd1, 1'b0};
                end
                if (accept) begin
                    ret_cnt_d = ret_cnt_q + 3'd1;
                end
                if (fill_last) begin
                    state_d    = IDLE;
                    mem_en_d   = 1'b0;
                    mem_addr_d = 16'h0000;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_d_q   <= 1'b0;
            issue_cnt_q <= 3'd0;
            ret_cnt_q   <= 3'd0;
            base_q      <= 12'h000;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_d_first_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            owner_d_q   <= owner_d_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            base_q      <= base_d;
            mem_en_q    <= mem_en_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
`ifdef MEM_ARB_RR_EN
            rr_d_first_q <= rr_d_first_d;
`endif
        end
    end

    // Return path is combinational so a word is handed over in the cycle memory delivers it.
    assign i_data_valid = accept && !owner_d_q;
    assign d_data_valid = accept && owner_d_q;
    assign fill_data    = accept ? mem_rdata : '0;
    assign fill_word    = accept ? ret_cnt_q : 3'd0;
    assign i_done       = fill_last && !owner_d_q;
    assign d_done       = (fill_last && owner_d_q) || (state_q == WRITE);
    assign busy         = busy_q;
    assign mem_en       = mem_en_q;
    assign mem_wr       = mem_wr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

endmodule
